// File: rtl/hdg_frwrd_gen.sv
// Heading-error / forward-speed generator feeding the PID for one move.
// Latency: error/err_vld/frwrd/moving/done are all registered, 1 clk after the input event.
// Backpressure: none; heading_rdy strobes are consumed every cycle. Optional macro FAST_SIM_EN scales the ramp step by 8.
module hdg_frwrd_gen #(
  parameter logic [9:0]  FRWRD_MAX  = 10'h300,
  parameter logic [9:0]  INC        = 10'd16,
  parameter logic [11:0] HDG_THRESH = 12'd96
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_go,
  input  logic        move_stop,
  input  logic [11:0] desired_heading,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  output logic [11:0] error,
  output logic        err_vld,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    CRUISE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

`ifdef FAST_SIM_EN
  // Coarse step so full-system sims reach cruise in a handful of samples.
  localparam logic [11:0] STEP_UP = {2'b00, INC} << 3;
`else
  localparam logic [11:0] STEP_UP = {2'b00, INC};
`endif
  // Deceleration is twice as aggressive as acceleration.
  localparam logic [11:0] STEP_DN = STEP_UP << 1;

  state_t      state_q, state_d;
  logic [11:0] des_hdg_q, des_hdg_d;
  logic [11:0] error_q, error_d;
  logic        err_vld_q, err_vld_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic        moving_q, moving_d;
  logic        done_q, done_d;

  logic [11:0] diff;
  logic [11:0] diff_abs;
  logic        over_thresh;
  logic [11:0] up_sum;
  logic [9:0]  up_sat;
  logic [9:0]  dn_sat;

  // Heading error, its magnitude, and the saturated ramp candidates.
  always_comb begin
    diff        = heading - des_hdg_q;
    // -2048 negates to 12'h800, which as unsigned is 2048 and so lands above threshold.
    diff_abs    = diff[11] ? (~diff + 12'd1) : diff;
    over_thresh = (diff_abs >= HDG_THRESH);
    up_sum      = {2'b00, frwrd_q} + STEP_UP;
    up_sat      = (up_sum >= {2'b00, FRWRD_MAX}) ? FRWRD_MAX : up_sum[9:0];
    dn_sat      = ({2'b00, frwrd_q} <= STEP_DN) ? 10'd0 : (frwrd_q - STEP_DN[9:0]);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    des_hdg_d = des_hdg_q;
    error_d   = heading_rdy ? diff : error_q;
    err_vld_d = heading_rdy;
    frwrd_d   = frwrd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        frwrd_d = 10'd0;
        // move_go takes priority over a coincident move_stop, which IDLE ignores anyway.
        if (move_go) begin
          des_hdg_d = desired_heading;
          state_d   = RAMP_UP;
        end
      end
      RAMP_UP: begin
        // Large heading error: hold speed and let the PID turn in place.
        if (heading_rdy && !over_thresh) begin
          frwrd_d = up_sat;
          if (up_sat == FRWRD_MAX) state_d = CRUISE;
        end
        // Stop overrides a simultaneous transition into CRUISE.
        if (move_stop) state_d = RAMP_DOWN;
      end
      CRUISE: begin
        if (move_stop) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (heading_rdy) begin
          frwrd_d = dn_sat;
          if (dn_sat == 10'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        frwrd_d = 10'd0;
      end
    endcase
    moving_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts a move with no ramp-down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      des_hdg_q <= 12'd0;
      error_q   <= 12'd0;
      err_vld_q <= 1'b0;
      frwrd_q   <= 10'd0;
      moving_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      des_hdg_q <= des_hdg_d;
      error_q   <= error_d;
      err_vld_q <= err_vld_d;
      frwrd_q   <= frwrd_d;
      moving_q  <= moving_d;
      done_q    <= done_d;
    end
  end

  assign error   = error_q;
  assign err_vld = err_vld_q;
  assign frwrd   = frwrd_q;
  assign moving  = moving_q;
  assign done    = done_q;

endmodule

// File: tb/tb_hdg_frwrd_gen.sv
// Directed bench for hdg_frwrd_gen: error path, ramp up/hold/cruise/down, wrap, reset abort.
// Inputs driven on negedge, outputs sampled on the following negedge.
// Ramp step follows FAST_SIM_EN so the same vectors cover both builds.
module tb_hdg_frwrd_gen;

`ifdef FAST_SIM_EN
  localparam int STEP = 128;
`else
  localparam int STEP = 16;
`endif
  localparam int FMAX = 768;

  logic        clk;
  logic        rst_n;
  logic        move_go;
  logic        move_stop;
  logic [11:0] desired_heading;
  logic [11:0] heading;
  logic        heading_rdy;
  logic [11:0] error;
  logic        err_vld;
  logic [9:0]  frwrd;
  logic        moving;
  logic        done;

  int n_chk;
  int n_fail;
  int exp_f;

  hdg_frwrd_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .move_go         (move_go),
    .move_stop       (move_stop),
    .desired_heading (desired_heading),
    .heading         (heading),
    .heading_rdy     (heading_rdy),
    .error           (error),
    .err_vld         (err_vld),
    .frwrd           (frwrd),
    .moving          (moving),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One heading sample; returns with the registered response visible.
  task automatic hdg(input logic [11:0] h, input logic stop);
    heading     = h;
    heading_rdy = 1'b1;
    move_stop   = stop;
    @(negedge clk);
    heading_rdy = 1'b0;
    move_stop   = 1'b0;
  endtask

  task automatic go(input logic [11:0] d, input logic stop);
    desired_heading = d;
    move_go         = 1'b1;
    move_stop       = stop;
    @(negedge clk);
    move_go         = 1'b0;
    move_stop       = 1'b0;
  endtask

  task automatic stop_pulse();
    move_stop = 1'b1;
    @(negedge clk);
    move_stop = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_frwrd", frwrd, 0);
    chk("rst_moving", moving, 0);
    chk("rst_done", done, 0);
    chk("rst_err_vld", err_vld, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic int up(input int f);
    return (f + STEP >= FMAX) ? FMAX : f + STEP;
  endfunction

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; move_go = 1'b0; move_stop = 1'b0;
    desired_heading = 12'h000; heading = 12'h000; heading_rdy = 1'b0;
    #1;
    chk("rst0_frwrd", frwrd, 0);
    chk("rst0_moving", moving, 0);
    chk("rst0_error", error, 0);
    chk("rst0_done", done, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE: error path runs, speed stays 0, move_stop ignored.
    for (int i = 0; i < 10; i++) begin
      hdg(12'h123, 1'b0);
      chk("idle_error", error, 12'h123);
      chk("idle_err_vld", err_vld, 1);
      chk("idle_frwrd", frwrd, 0);
      chk("idle_moving", moving, 0);
    end
    @(negedge clk);
    chk("idle_err_vld_low", err_vld, 0);
    stop_pulse();
    chk("idle_stop_ignored", moving, 0);

    // Full ramp up to cruise.
    go(12'h000, 1'b0);
    chk("go_moving", moving, 1);
    chk("go_frwrd", frwrd, 0);
    exp_f = 0;
    for (int i = 0; i < 51; i++) begin
      hdg(12'h000, 1'b0);
      exp_f = up(exp_f);
      chk("ramp_up", frwrd, exp_f);
    end
    chk("cruise_frwrd", frwrd, FMAX);

    // Ramp down from cruise to done.
    stop_pulse();
    chk("stop_moving", moving, 1);
    for (int i = 0; i < FMAX / (2 * STEP); i++) begin
      chk("dn_no_done", done, 0);
      hdg(12'h000, 1'b0);
      exp_f = exp_f - 2 * STEP;
      chk("ramp_dn", frwrd, exp_f);
    end
    chk("dn_done", done, 1);
    chk("dn_moving", moving, 0);
    @(negedge clk);
    chk("dn_done_1clk", done, 0);

    // Threshold hold during ramp up.
    go(12'h000, 1'b0);
    exp_f = 0;
    for (int i = 0; i < 4; i++) begin
      hdg(12'h000, 1'b0);
      exp_f = up(exp_f);
    end
    chk("thr_start", frwrd, exp_f);
    for (int i = 0; i < 5; i++) begin
      hdg(12'h100, 1'b0);
      chk("thr_hold", frwrd, exp_f);
      chk("thr_error", error, 12'h100);
    end
    hdg(12'h010, 1'b0);
    exp_f = up(exp_f);
    chk("thr_resume", frwrd, exp_f);
    hdg(12'h800, 1'b0);
    chk("thr_min_neg", frwrd, exp_f);
    hdg(12'h060, 1'b0);
    chk("thr_eq96", frwrd, exp_f);
    hdg(12'hFA0, 1'b0);
    chk("thr_neg96", frwrd, exp_f);
    hdg(12'h05F, 1'b0);
    exp_f = up(exp_f);
    chk("thr_95", frwrd, exp_f);

    // move_go while moving: no reload of desired heading.
    go(12'h555, 1'b0);
    hdg(12'h000, 1'b0);
    exp_f = up(exp_f);
    chk("go_ignored_err", error, 12'h000);
    chk("go_ignored_frwrd", frwrd, exp_f);

    // move_stop with a sample: current-state rule applies to that sample, then ramp down.
    hdg(12'h000, 1'b1);
    exp_f = up(exp_f);
    chk("stop_same_smp", frwrd, exp_f);
    hdg(12'h100, 1'b0);
    exp_f = (exp_f > 2 * STEP) ? exp_f - 2 * STEP : 0;
    chk("dn_no_thresh", frwrd, exp_f);
    chk("dn_still_moving", moving, (exp_f != 0) ? 1 : 0);

    // Abort mid ramp-down: no done pulse afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end

    // Wrap cases, with go and stop coincident in IDLE.
    go(12'h7F0, 1'b1);
    chk("go_wins", moving, 1);
    hdg(12'h810, 1'b0);
    chk("wrap_err1", error, 12'h020);
    chk("wrap_frwrd1", frwrd, STEP);
    do_reset();
    go(12'h010, 1'b0);
    hdg(12'hFF0, 1'b0);
    chk("wrap_err2", error, 12'hFE0);
    chk("wrap_frwrd2", frwrd, STEP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdg_frwrd_gen.md
Name: hdg_frwrd_gen

Overview:
- Produces the PID's inputs `error`, `err_vld`, `frwrd` and `moving` for one move.
- Sits between the command processor and the PID. It latches a desired heading and forms heading error from each new inertial heading sample.
- Ramps forward speed up, holds it, and ramps it down when told to stop. Pulses `done` when the robot is stationary again.

Parameters:
- FRWRD_MAX, 10'h300, saturation ceiling for `frwrd`.
- INC, 10'd16, `frwrd` ramp-up step per heading sample; ramp-down step is 2*INC.
- HDG_THRESH, 12'd96, `frwrd` is held (no ramp-up) while |error| >= this.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- move_go  in  1  one-cycle pulse: latch desired_heading, begin move
- move_stop  in  1  one-cycle pulse: begin ramp-down
- desired_heading  in  12  signed target heading; sampled only on an accepted move_go
- heading  in  12  signed current heading from the inertial interface
- heading_rdy  in  1  one-cycle strobe: heading is new
- error  out  12  signed heading error to PID
- err_vld  out  1  error-valid strobe to PID
- frwrd  out  10  unsigned forward speed to PID
- moving  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a move finishes

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; error, err_vld, frwrd, moving, done and the desired-heading register all 0. Reset asserted mid-move aborts immediately, with no ramp-down.
- Error path:
  - On every heading_rdy, in any state, error <= heading - des_hdg_reg, 12-bit two's-complement wrap. Example: 12'h010 - 12'hFF0 = 12'h020.
  - err_vld is a registered copy of heading_rdy, so it is high in the same cycle error updates. Latency is 1 clk from heading_rdy.
- Threshold test: uses |new difference| formed in the heading_rdy cycle. The value -2048 counts as above threshold.
- frwrd changes only on heading_rdy cycles and only in RAMP_UP or RAMP_DOWN.
- States:
  - IDLE:
    - moving=0 and frwrd=0.
    - move_go: des_hdg_reg <= desired_heading, go to RAMP_UP.
    - move_stop is ignored. If move_go and move_stop arrive together, move_go wins.
  - RAMP_UP:
    - On heading_rdy with |diff| < HDG_THRESH: frwrd <= min(frwrd+INC, FRWRD_MAX).
    - When the result equals FRWRD_MAX, go to CRUISE.
    - If |diff| >= HDG_THRESH, frwrd holds (robot turns in place).
    - move_stop goes to RAMP_DOWN.
  - CRUISE: frwrd holds; move_stop goes to RAMP_DOWN.
  - RAMP_DOWN:
    - On heading_rdy: frwrd <= max(frwrd-2*INC, 0), with no underflow.
    - When the result is 0, go to IDLE and pulse done for 1 clk.
    - Both the done pulse and moving falling occur in the cycle after that heading_rdy.
    - If already 0 on entry, the next heading_rdy completes the move.
- move_go outside IDLE is ignored; des_hdg_reg is not reloaded.
- move_stop in the same cycle as heading_rdy: the transition to RAMP_DOWN takes effect, and that sample applies the ramp-up or hold rule of the current state.
- Threshold gating does not apply in RAMP_DOWN.
- moving is registered and is decoded from the next state, so it is high the cycle after move_go.

Optional Feature:
- Macro: FAST_SIM_EN.
- Defined: effective step is INC<<3 (128 up, 256 down with defaults), so full-system simulations ramp in few samples. Saturation rules are unchanged.
- Undefined: step is INC.

Test Plan:
- Reset then 10 heading_rdy pulses with heading=12'h123: error updates to 12'h123 (des_hdg_reg=0), err_vld pulses each 1 clk later, frwrd=0, moving=0.
- desired_heading=12'h000, move_go, then heading=12'h000 on 48 heading_rdy pulses: frwrd steps 16,32,...,768 (10'h300), CRUISE entered, further pulses leave frwrd=10'h300.
- In RAMP_UP at frwrd=64, heading=12'h100 (|error|=256 ≥ 96) for 5 pulses: frwrd stays 64, error=12'h100. Then heading=12'h010: frwrd=80.
- From CRUISE at 768, move_stop, then 24 heading_rdy pulses: frwrd 736,...,0, done one-cycle pulse after the 24th, moving=0 and state IDLE.
- Wrap: desired_heading=12'h7F0, heading=12'h810 → error=12'h020. Desired 12'h010, heading 12'hFF0 → error=12'hFE0 (-32), ramp still proceeds.
- rst_n low mid-RAMP_DOWN at frwrd=400: all outputs 0 asynchronously, no done pulse. With FAST_SIM_EN: ramp-up takes 6 pulses, ramp-down 3.
